wishbone_master_mc: RTL

Parametrised multi-slave Wishbone classic master for the peripheral address window of the RV32 core. It accepts one CPU load or store at a time, decodes a slave index from the address, and runs a registered Wishbone cycle to that slave. It stalls the CPU until the cycle completes, returns latched read data, and reports bus errors and timeouts. Unlike the previous master, it handles reads as well as writes, supports per-slave `err`, supports a parametrised slave count, and has a watchdog timeout.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_slave_decode.sv | 43 ++++
 rtl/wishbone_master_mc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the multi-slave Wishbone classic master.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int WB_IDX_W  = 3;
  localparam int WB_TMO_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  // Byte-select for a CPU access: the write mask for stores, all lanes for loads.
  function automatic logic [WB_SEL_W-1:0] sel_for(input logic [WB_SEL_W-1:0] we);
    return (we != '0) ? we : {WB_SEL_W{1'b1}};
  endfunction

endpackage

// File: rtl/wb_slave_decode.sv
// Combinational slave decoder: turns a slave index into a one-hot select,
// flags indices beyond the attached slave count, and muxes ack/err/data
// from the selected slave only.
module wb_slave_decode
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic [WB_IDX_W-1:0]             idx,
  input  logic [NUM_SLAVES-1:0]           s_ack_i,
  input  logic [NUM_SLAVES-1:0]           s_err_i,
  input  logic [WB_DATA_W*NUM_SLAVES-1:0] s_dat_i,
  output logic [NUM_SLAVES-1:0]           onehot,
  output logic                            valid,
  output logic                            ack,
  output logic                            err,
  output logic [WB_DATA_W-1:0]            dat
);

  localparam logic [WB_IDX_W:0] NUM_SLAVES_L = NUM_SLAVES[WB_IDX_W:0];

  // An index is usable only if a slave is attached at that position.
  assign valid = {1'b0, idx} < NUM_SLAVES_L;

  // Select and response mux; unselected slaves never reach the outputs.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    onehot = '0;
    ack    = 1'b0;
    err    = 1'b0;
    dat    = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx == WB_IDX_W'(k)) begin
        onehot[k] = 1'b1;
        ack       = s_ack_i[k];
        err       = s_err_i[k];
        dat       = s_dat_i[WB_DATA_W*k +: WB_DATA_W];
      end
    end
  end

endmodule

// File: rtl/wishbone_master_mc.sv
// Multi-slave Wishbone classic master for the RV32 peripheral window.
// Takes one CPU load/store at a time, decodes the slave from the address,
// runs a registered Wishbone cycle, stalls the CPU until ack/err/timeout,
// then presents a one-cycle response with latched read data.
module wishbone_master_mc
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADR_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            mem_req_i,
  input  logic [WB_SEL_W-1:0]             mem_we_i,
  input  logic [31:0]                     mem_addr_i,
  input  logic [WB_DATA_W-1:0]            mem_data_i,
  output logic [WB_DATA_W-1:0]            mem_data_o,
  output logic                            stall_o,
  output logic                            err_o,
  input  logic [NUM_SLAVES-1:0]           s_ack_i,
  input  logic [NUM_SLAVES-1:0]           s_err_i,
  input  logic [WB_DATA_W*NUM_SLAVES-1:0] s_dat_i,
  output logic [NUM_SLAVES-1:0]           s_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [WB_SEL_W-1:0]             wb_sel_o,
  output logic [ADR_W-1:0]                wb_adr_o,
  output logic [WB_DATA_W-1:0]            wb_dat_o
);

  // Last BUS cycle count at which the watchdog still allows waiting.
  localparam logic [WB_TMO_W-1:0] TMO_LAST = WB_TMO_W'(TIMEOUT - 1);

  wb_state_t               state_q, state_d;
  logic [WB_IDX_W-1:0]     idx_q;
  logic [WB_IDX_W-1:0]     req_idx;
  logic [WB_IDX_W-1:0]     dec_idx;
  logic [WB_TMO_W-1:0]     tmo_q;
  logic [NUM_SLAVES-1:0]   cyc_q;
  logic                    stb_q;
  logic                    err_q;

  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    dec_valid;
  logic                    dec_ack;
  logic                    dec_err;
  logic [WB_DATA_W-1:0]    dec_dat;

  logic                    accept;
  logic                    in_bus;
  logic                    tmo_hit;
  logic                    bus_err;
  logic                    bus_ack;
  logic                    bus_tmo;
  logic                    bus_done;

  // Address bits above the slave index do not take part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_i[31:ADR_W+3];

  assign req_idx = mem_addr_i[ADR_W+2:ADR_W];

  // In IDLE decode the incoming request; in BUS/RESP the latched slave.
  assign dec_idx = (state_q == ST_IDLE) ? req_idx : idx_q;

  wb_slave_decode #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decode (
    .idx     (dec_idx),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_dat_i (s_dat_i),
    .onehot  (dec_onehot),
    .valid   (dec_valid),
    .ack     (dec_ack),
    .err     (dec_err),
    .dat     (dec_dat)
  );

  // Bus-cycle events; err beats ack, and either beats the watchdog.
  assign accept   = (state_q == ST_IDLE) && mem_req_i;
  assign in_bus   = (state_q == ST_BUS);
  assign tmo_hit  = (tmo_q >= TMO_LAST);
  assign bus_err  = in_bus && dec_err;
  assign bus_ack  = in_bus && dec_ack && !dec_err;
  assign bus_tmo  = in_bus && !dec_ack && !dec_err && tmo_hit;
  assign bus_done = bus_err || bus_ack || bus_tmo;

  // Next-state logic for IDLE -> BUS/RESP -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)   state_d = dec_valid ? ST_BUS : ST_RESP;
      ST_BUS:  if (bus_done) state_d = ST_RESP;
      ST_RESP:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Capture the CPU request into the shared bus registers when accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      idx_q    <= '0;
    end else if (accept) begin
      wb_adr_o <= mem_addr_i[ADR_W-1:0];
      wb_dat_o <= mem_data_i;
      wb_we_o  <= |mem_we_i;
      wb_sel_o <= sel_for(mem_we_i);
      idx_q    <= req_idx;
    end
  end

  // Cycle/strobe: raised for a decodable request, dropped when BUS ends.
  // Asynchronous reset drops them immediately, abandoning any cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q <= '0;
      stb_q <= 1'b0;
    end else if (accept && dec_valid) begin
      cyc_q <= dec_onehot;
      stb_q <= 1'b1;
    end else if (bus_done) begin
      cyc_q <= '0;
      stb_q <= 1'b0;
    end
  end

  // Watchdog: cleared on entry to BUS, counts BUS cycles, saturates.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= '0;
    end else if (accept) begin
      tmo_q <= '0;
    end else if (in_bus && (tmo_q != {WB_TMO_W{1'b1}})) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Response: error flag lives only through RESP; load data is updated
  // on a successful read and cleared on any failure.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q      <= 1'b0;
      mem_data_o <= '0;
    end else if ((accept && !dec_valid) || bus_err || bus_tmo) begin
      err_q      <= 1'b1;
      mem_data_o <= '0;
    end else if (bus_ack) begin
      err_q <= 1'b0;
      if (!wb_we_o) mem_data_o <= dec_dat;
    end else if (state_q == ST_RESP) begin
      err_q <= 1'b0;
    end
  end

  assign s_cyc_o  = cyc_q;
  assign wb_stb_o = stb_q;
  assign err_o    = err_q;
  assign stall_o  = accept || in_bus;

endmodule
